// File: rtl/scalar_radix16_recoder.sv
// rtl/scalar_radix16_recoder.sv - signed radix-16 recoder for Ed25519 scalars
// Streams NDIG digits in [-8,8] (final digit unclipped), least significant first.
module scalar_radix16_recoder #(
  parameter int SCALAR_BYTES = 32,
  parameter int DIGIT_W      = 8,
  localparam int NDIG        = 2 * SCALAR_BYTES,
  localparam int IDX_W       = $clog2(NDIG),
  localparam int SW          = 8 * SCALAR_BYTES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [SW-1:0]      s_scalar,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DIGIT_W-1:0] m_digit,
  output logic [IDX_W-1:0]   m_index,
  output logic               m_last,
  output logic               busy,
  output logic               err_msb
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      sr_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic               err_q;

  logic [4:0]         t;
  logic               is_last;
  logic               c_next;
  logic [DIGIT_W-1:0] digit;
  logic               load;
  logic               beat;

  // Digit datapath: only the low nibble plus incoming carry matters each beat.
  always_comb begin
    t       = {1'b0, sr_q[3:0]} + {4'b0000, carry_q};
    is_last = (idx_q == IDX_W'(NDIG - 1));
    c_next  = !is_last && (t >= 5'd8);
    digit   = {{(DIGIT_W-5){1'b0}}, t} - (c_next ? DIGIT_W'(16) : DIGIT_W'(0));
  end

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    busy    = 1'b0;
    m_last  = 1'b0;
    m_digit = '0;
    load    = 1'b0;
    beat    = 1'b0;
    case (state_q)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        m_last  = is_last;
        m_digit = digit;
        if (m_ready) begin
          beat = 1'b1;
          if (is_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_index = idx_q;
  assign err_msb = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        sr_q    <= s_scalar;
        carry_q <= 1'b0;
        idx_q   <= '0;
        err_q   <= s_scalar[SW-1];
      end else if (beat) begin
        sr_q    <= sr_q >> 4;
        carry_q <= c_next;
        // wraps to zero after the final digit so IDLE shows index 0
        idx_q   <= idx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_scalar_radix16_recoder.sv
// tb/tb_scalar_radix16_recoder.sv - directed self-checking bench for scalar_radix16_recoder
// Drives and samples on the falling edge; DUT registers on the rising edge.
module tb_scalar_radix16_recoder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic [255:0] s_scalar;
  logic         m_valid;
  logic         m_ready;
  logic [7:0]   m_digit;
  logic [5:0]   m_index;
  logic         m_last;
  logic         busy;
  logic         err_msb;

  int checks = 0;
  int errors = 0;
  logic [7:0] dig [64];

  always #5 clk = ~clk;

  scalar_radix16_recoder #(.SCALAR_BYTES(32), .DIGIT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_scalar(s_scalar),
    .m_valid(m_valid), .m_ready(m_ready), .m_digit(m_digit), .m_index(m_index),
    .m_last(m_last), .busy(busy), .err_msb(err_msb)
  );

  // Runs one job from a falling edge, collects digits into dig[], checks protocol and sum.
  task automatic run_job(input string nm, input logic [255:0] sc, input bit toggle);
    int n, cyc, guard;
    bit stalled;
    logic [7:0] hd;
    logic [5:0] hi;
    logic hl;
    logic signed [271:0] acc;
    s_scalar = sc;
    s_valid  = 1'b1;
    m_ready  = 1'b1;
    guard    = 0;
    while (!s_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!s_ready) begin
      $display("FAIL %s accept: s_ready=%0b required 1", nm, s_ready);
      errors++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL %s first_beat: m_valid=%0b s_ready=%0b busy=%0b required 1 0 1",
               nm, m_valid, s_ready, busy);
      errors++;
    end
    checks++;
    if (err_msb !== sc[255]) begin
      $display("FAIL %s err_msb: got %0b required %0b", nm, err_msb, sc[255]);
      errors++;
    end
    n = 0; cyc = 0; stalled = 0;
    hd = '0; hi = '0; hl = 1'b0;
    while (n < 64 && cyc < 400) begin
      if (stalled) begin
        checks++;
        if (m_digit !== hd || m_index !== hi || m_last !== hl) begin
          $display("FAIL %s stall_hold: digit=%h idx=%0d last=%0b required %h %0d %0b",
                   nm, m_digit, m_index, m_last, hd, hi, hl);
          errors++;
        end
      end
      m_ready = toggle ? cyc[0] : 1'b1;
      if (m_valid && m_ready) begin
        dig[n] = m_digit;
        checks++;
        if (m_index !== 6'(n) || m_last !== (n == 63)) begin
          $display("FAIL %s beat: idx=%0d last=%0b required %0d %0b",
                   nm, m_index, m_last, n, (n == 63));
          errors++;
        end
        n++;
        stalled = 0;
      end else if (m_valid) begin
        stalled = 1;
        hd = m_digit; hi = m_index; hl = m_last;
      end
      cyc++;
      @(negedge clk);
    end
    m_ready = 1'b1;
    checks++;
    if (n != 64 || cyc != (toggle ? 128 : 64)) begin
      $display("FAIL %s beat_count: beats=%0d cycles=%0d required 64 %0d",
               nm, n, cyc, toggle ? 128 : 64);
      errors++;
    end
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL %s return_idle: s_ready=%0b m_valid=%0b busy=%0b required 1 0 0",
               nm, s_ready, m_valid, busy);
      errors++;
    end
    acc = '0;
    for (int i = 0; i < 64; i++)
      acc = acc + ($signed({{264{dig[i][7]}}, dig[i]}) <<< (4 * i));
    checks++;
    if (acc !== {16'b0, sc}) begin
      $display("FAIL %s reconstruct: sum=%h required %h", nm, acc, sc);
      errors++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b1; s_scalar = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0 ||
        m_index !== 6'd0 || err_msb !== 1'b0 || m_digit !== 8'h00) begin
      $display("FAIL reset: rdy=%0b vld=%0b busy=%0b last=%0b idx=%0d err=%0b dig=%h required 1 0 0 0 0 0 00",
               s_ready, m_valid, busy, m_last, m_index, err_msb, m_digit);
      errors++;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    run_job("zero", 256'h0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (dig[i] !== 8'h00) begin
        $display("FAIL zero e%0d: got %h required 00", i, dig[i]);
        errors++;
      end
    end
  endtask

  task automatic test_small();
    logic [7:0] ev;
    run_job("eight", 256'h08, 1'b0);
    for (int i = 0; i < 64; i++) begin
      ev = (i == 0) ? 8'hF8 : (i == 1) ? 8'h01 : 8'h00;
      checks++;
      if (dig[i] !== ev) begin
        $display("FAIL eight e%0d: got %h required %h", i, dig[i], ev);
        errors++;
      end
    end
    run_job("ff", 256'hFF, 1'b0);
    for (int i = 0; i < 64; i++) begin
      ev = (i == 0) ? 8'hFF : (i == 2) ? 8'h01 : 8'h00;
      checks++;
      if (dig[i] !== ev) begin
        $display("FAIL ff e%0d: got %h required %h", i, dig[i], ev);
        errors++;
      end
    end
  endtask

  task automatic test_sevens();
    logic [255:0] sc;
    sc = {32{8'h77}};
    run_job("sevens", sc, 1'b0);
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (dig[i] !== 8'h07) begin
        $display("FAIL sevens e%0d: got %h required 07", i, dig[i]);
        errors++;
      end
    end
    run_job("sevens_stall", sc, 1'b1);
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (dig[i] !== 8'h07) begin
        $display("FAIL sevens_stall e%0d: got %h required 07", i, dig[i]);
        errors++;
      end
    end
  endtask

  task automatic test_msb();
    logic [7:0] ev;
    run_job("top80", {8'h80, 248'h0}, 1'b0);
    for (int i = 0; i < 64; i++) begin
      ev = (i == 63) ? 8'h08 : 8'h00;
      checks++;
      if (dig[i] !== ev) begin
        $display("FAIL top80 e%0d: got %h required %h", i, dig[i], ev);
        errors++;
      end
    end
    run_job("ones", {256{1'b1}}, 1'b0);
    for (int i = 0; i < 64; i++) begin
      ev = (i == 0) ? 8'hFF : (i == 63) ? 8'h10 : 8'h00;
      checks++;
      if (dig[i] !== ev) begin
        $display("FAIL ones e%0d: got %h required %h", i, dig[i], ev);
        errors++;
      end
    end
  endtask

  task automatic test_reset_midjob();
    int guard;
    s_scalar = {256{1'b1}};
    s_valid  = 1'b1;
    m_ready  = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    guard = 0;
    while (m_index != 6'd20 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (m_index !== 6'd20 || err_msb !== 1'b1) begin
      $display("FAIL midjob reach: idx=%0d err=%0b required 20 1", m_index, err_msb);
      errors++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || err_msb !== 1'b0 || m_index !== 6'd0 || busy !== 1'b0) begin
      $display("FAIL midjob abort: vld=%0b rdy=%0b err=%0b idx=%0d busy=%0b required 0 1 0 0 0",
               m_valid, s_ready, err_msb, m_index, busy);
      errors++;
    end
    run_job("after_reset", 256'h1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (dig[i] !== ((i == 0) ? 8'h01 : 8'h00)) begin
        $display("FAIL after_reset e%0d: got %h required %h", i, dig[i], (i == 0) ? 8'h01 : 8'h00);
        errors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_small();
    test_sevens();
    test_msb();
    test_reset_midjob();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
